// File: rtl/deserializer_sipo.sv
// Serial-in/parallel-out receiver: start bit, DATA_WIDTH data bits LSB first, stop bit.
// Define PARITY_CHECK_EN to expect an even-parity bit between the data and the stop bit.
module deserializer_sipo #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  srl_in,
   input  logic                  bit_en,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  frame_err,
   output logic                  parity_err,
   output logic                  overrun_err
);

   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overrun_err_q, overrun_err_d;
   logic                  start_en, shift_en, par_en, stop_en;
   logic                  last_bit, parity_ok, word_good, load;

   assign last_bit = (cnt_q == CW'(DATA_WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bit_en) begin
         case (state_q)
            S_IDLE:   if (!srl_in) state_d = S_DATA;
            S_DATA: begin
               if (last_bit) begin
`ifdef PARITY_CHECK_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
            S_PARITY: state_d = S_STOP;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      start_en = bit_en && (state_q == S_IDLE) && !srl_in;
      shift_en = bit_en && (state_q == S_DATA);
      par_en   = bit_en && (state_q == S_PARITY);
      stop_en  = bit_en && (state_q == S_STOP);
   end

`ifdef PARITY_CHECK_EN
   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (par_en) par_d = srl_in;
   end

   always_ff @(posedge clk) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end

   logic parity_err_q, parity_err_d;

   // Even parity: data bits and the parity bit together must XOR to zero.
   assign parity_ok    = ~(^shift_q ^ par_q);
   assign parity_err_d = stop_en && !parity_ok;

   always_ff @(posedge clk) begin
      if (rst) parity_err_q <= 1'b0;
      else     parity_err_q <= parity_err_d;
   end

   assign parity_err = parity_err_q;
`else
   logic unused_par_en;

   assign unused_par_en = par_en;
   assign parity_ok     = 1'b1;
   assign parity_err    = 1'b0;
`endif

   // Output handshake: a word transfers on an edge where out_valid & out_ready;
   // out_valid then stays high only if a new word is loaded on that same edge.
   always_comb begin
      cnt_d         = cnt_q;
      shift_d       = shift_q;
      word_good     = stop_en && srl_in && parity_ok;
      load          = word_good && (!out_valid_q || out_ready);
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      frame_err_d   = stop_en && !srl_in;
      overrun_err_d = word_good && out_valid_q && !out_ready;
      if (start_en) begin
         cnt_d = '0;
      end else if (shift_en) begin
         shift_d = {srl_in, shift_q[DATA_WIDTH-1:1]};
         cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
      end
      if (load) begin
         out_data_d  = shift_q;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         shift_q       <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         shift_q       <= shift_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_err_q;

endmodule
